keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 51 +++++
 rtl/sync_2ff.sv | 27 ++
 rtl/keypad_scanner.sv | 165 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x3 keypad scanner.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int ROW_W    = 2;
    localparam int COL_W    = 2;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    // Active-low one-cold column drive for a column index.
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [COL_W-1:0] idx);
        logic [NUM_COLS-1:0] d;
        d = '1;
        for (int i = 0; i < NUM_COLS; i++) begin
            d[i] = (idx != COL_W'(i));
        end
        return d;
    endfunction

    // Column index that follows idx in the 0,1,2,0,... scan order.
    function automatic logic [COL_W-1:0] col_next(input logic [COL_W-1:0] idx);
        logic [COL_W-1:0] n;
        if (idx == COL_W'(NUM_COLS - 1)) begin
            n = '0;
        end else begin
            n = idx + COL_W'(1);
        end
        return n;
    endfunction

    // Index of the lowest-numbered row that reads low (0 when none do).
    function automatic logic [ROW_W-1:0] lowest_low(input logic [NUM_ROWS-1:0] rows);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                r = ROW_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; q simply follows d two cycles late.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; reset loads the idle level into both.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with debounce; optional auto-repeat when KEYPAD_AUTO_REPEAT_EN is defined.
// Latency: key seen at the end of a column dwell, key_valid DEBOUNCE_CNT cycles later (+2 sync cycles).
// Backpressure: none; key_valid is a one-cycle pulse with no handshake, RowOut/ColOut hold the last key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 4,
    parameter int DEBOUNCE_CNT  = 8,
    parameter int REPEAT_DLY    = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic [ROW_W-1:0]    RowOut,
    output logic [COL_W-1:0]    ColOut,
    output logic                key_valid,
    output logic                key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

    state_t              state;
    logic [COL_W-1:0]    col;
    logic [COL_W-1:0]    col_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic [DEB_W-1:0]    deb_cnt;
    logic [ROW_W-1:0]    cap_row;
    logic [NUM_ROWS-1:0] row_s;
    logic                any_low;
    logic                cap_low;
    logic                rep_fire;

    sync_2ff #(
        .WIDTH   (NUM_ROWS),
        .RST_VAL ({NUM_ROWS{1'b1}})
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_n),
        .q   (row_s)
    );

    assign col_nxt = col_next(col);
    assign any_low = ~&row_s;
    assign cap_low = ~row_s[cap_row];

`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PERIOD) ? REPEAT_DLY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_armed;

    // First repeat waits REPEAT_DLY held cycles, later ones REPEAT_PERIOD.
    assign rep_fire = (state == PRESSED) && cap_low &&
                      (rep_cnt == (rep_armed ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DLY - 1)));

    // Held-cycle counter: cleared before each new press, paused across a release glitch.
    always_ff @(posedge clk) begin
        if (rst || state == SCAN || state == DEBOUNCE) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (state == PRESSED && cap_low) begin
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b1;
            end else if (rep_cnt != REP_W'(REP_MAX)) begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
        end
    end
`else
    logic unused_repeat_cfg;

    // Repeat parameters stay referenced even though the repeat counter is compiled out.
    assign unused_repeat_cfg = (REPEAT_DLY > 0) ^ (REPEAT_PERIOD > 0);
    assign rep_fire          = 1'b0;
`endif

    // Scan / debounce / hold / release-debounce state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            col       <= '0;
            col_n     <= col_drive('0);
            div_cnt   <= '0;
            deb_cnt   <= '0;
            cap_row   <= '0;
            RowOut    <= '0;
            ColOut    <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            unique case (state)
                SCAN: begin
                    // Rows are only trusted at the end of a dwell, after the sync delay settles.
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (any_low) begin
                            cap_row <= lowest_low(row_s);
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col   <= col_nxt;
                            col_n <= col_drive(col_nxt);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (cap_low) begin
                        if (deb_cnt >= DEB_LAST) begin
                            deb_cnt   <= '0;
                            RowOut    <= cap_row;
                            ColOut    <= col;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            state     <= PRESSED;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        deb_cnt <= '0;
                        div_cnt <= '0;
                        col     <= col_nxt;
                        col_n   <= col_drive(col_nxt);
                        state   <= SCAN;
                    end
                end
                PRESSED: begin
                    // The first high sample already counts toward the release debounce.
                    if (!cap_low) begin
                        deb_cnt <= DEB_W'(1);
                        state   <= RELEASE;
                    end else if (rep_fire) begin
                        key_valid <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (cap_low) begin
                        deb_cnt <= '0;
                        state   <= PRESSED;
                    end else if (deb_cnt >= DEB_LAST) begin
                        deb_cnt  <= '0;
                        div_cnt  <= '0;
                        key_held <= 1'b0;
                        col      <= col_nxt;
                        col_n    <= col_drive(col_nxt);
                        state    <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: idle scan, press/hold/release, bounce, release glitch, multi-key, reset abort, repeat.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic [1:0] RowOut;
    logic [1:0] ColOut;
    logic       key_valid;
    logic       key_held;

    // keys[r][c] = 1 means the switch at row r, column c is closed.
    logic [3:0][2:0] keys;
    logic [2:0]      col_pat [3];

    int n_vec    = 0;
    int n_miscmp = 0;
    int kv_total = 0;
    int kv_mark;
    int offs [$];

    always #5 clk = ~clk;

    // Passive keypad: a closed switch pulls its row low while its column is driven low.
    always_comb begin
        row_n = '1;
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(keys[r] & ~col_n);
        end
    end

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_CNT  (8),
        .REPEAT_DLY    (64),
        .REPEAT_PERIOD (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .RowOut    (RowOut),
        .ColOut    (ColOut),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n cycles, sampling on the falling edge and counting key_valid pulses.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) kv_total++;
        end
    endtask

    // Wait (bounded) for key_valid and check how many cycles it took.
    task automatic wait_valid(input string tag, input int exp_lat, input int budget);
        int lat;
        lat = 0;
        do begin
            step(1);
            lat++;
        end while (key_valid !== 1'b1 && lat < budget);
        if (key_valid !== 1'b1) lat = budget + 1;
        chk(tag, lat, exp_lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        col_pat[0] = 3'b110;
        col_pat[1] = 3'b101;
        col_pat[2] = 3'b011;
        keys = '0;
        rst  = 1'b1;
        step(3);

        // Reset state.
        chk("rst col_n", col_n, 3'b110);
        chk("rst RowOut", RowOut, 0);
        chk("rst ColOut", ColOut, 0);
        chk("rst key_valid", key_valid, 0);
        chk("rst key_held", key_held, 0);
        rst = 1'b0;

        // Idle scan: column changes every 4 cycles, no key events.
        for (int k = 1; k <= 30; k++) begin
            step(1);
            chk("idle col_n", col_n, col_pat[(k / 4) % 3]);
        end
        chk("idle key_valid count", kv_total, 0);
        chk("idle RowOut", RowOut, 0);
        chk("idle ColOut", ColOut, 0);

        // Key r2/c1 held 40 cycles: missed at edge 32, captured at edge 44, accepted at edge 52.
        kv_mark = kv_total;
        keys[2][1] = 1'b1;
        wait_valid("r2c1 accept latency", 22, 40);
        chk("r2c1 RowOut", RowOut, 2);
        chk("r2c1 ColOut", ColOut, 1);
        chk("r2c1 key_held", key_held, 1);
        chk("r2c1 col frozen", col_n, 3'b101);
        step(1);
        chk("r2c1 pulse width", key_valid, 0);
        step(17);
        chk("r2c1 held at release", key_held, 1);
        keys[2][1] = 1'b0;
        step(9);
        chk("r2c1 held before debounce end", key_held, 1);
        step(1);
        chk("r2c1 held cleared", key_held, 0);
        chk("r2c1 scan next col", col_n, 3'b011);
        chk("r2c1 single key_valid", kv_total - kv_mark, 1);

        // Bounce: row 0 low for 5 cycles on col 2 enters debounce, then aborts to col 0.
        kv_mark = kv_total;
        keys[0][2] = 1'b1;
        step(5);
        chk("bounce col frozen", col_n, 3'b011);
        keys[0][2] = 1'b0;
        step(3);
        chk("bounce next col", col_n, 3'b110);
        chk("bounce no key_valid", kv_total - kv_mark, 0);
        chk("bounce RowOut kept", RowOut, 2);
        chk("bounce ColOut kept", ColOut, 1);

        // Release glitch: key r1/c0 opens for 3 cycles and closes again.
        kv_mark = kv_total;
        keys[1][0] = 1'b1;
        wait_valid("r1c0 accept latency", 12, 40);
        chk("r1c0 RowOut", RowOut, 1);
        chk("r1c0 ColOut", ColOut, 0);
        step(5);
        keys[1][0] = 1'b0;
        step(3);
        keys[1][0] = 1'b1;
        for (int k = 0; k < 22; k++) begin
            step(1);
            chk("glitch key_held", key_held, 1);
        end
        chk("glitch single key_valid", kv_total - kv_mark, 1);
        keys[1][0] = 1'b0;
        step(9);
        chk("glitch held before debounce end", key_held, 1);
        step(1);
        chk("glitch held cleared", key_held, 0);
        chk("glitch scan next col", col_n, 3'b101);

        // Two keys on col 2 (rows 1 and 3): lowest row wins.
        keys[1][2] = 1'b1;
        keys[3][2] = 1'b1;
        wait_valid("multi accept latency", 16, 40);
        chk("multi RowOut", RowOut, 1);
        chk("multi ColOut", ColOut, 2);
        step(4);
        keys[1][2] = 1'b0;
        keys[3][2] = 1'b0;
        step(10);
        chk("multi held cleared", key_held, 0);
        chk("multi RowOut kept", RowOut, 1);
        chk("multi ColOut kept", ColOut, 2);

        // Reset in the middle of debounce of key r0/c0.
        kv_mark = kv_total;
        keys[0][0] = 1'b1;
        step(6);
        chk("rstdeb col frozen", col_n, 3'b110);
        rst = 1'b1;
        step(1);
        chk("rstdeb col_n", col_n, 3'b110);
        chk("rstdeb RowOut", RowOut, 0);
        chk("rstdeb ColOut", ColOut, 0);
        chk("rstdeb key_valid", key_valid, 0);
        chk("rstdeb key_held", key_held, 0);
        rst = 1'b0;
        keys[0][0] = 1'b0;
        step(4);
        chk("rstdeb scan restart", col_n, 3'b101);
        step(8);
        chk("rstdeb no key_valid", kv_total - kv_mark, 0);

        // Long hold of key r3/c0 for 120 cycles past acceptance.
        keys[3][0] = 1'b1;
        wait_valid("hold accept latency", 12, 40);
        chk("hold RowOut", RowOut, 3);
        chk("hold ColOut", ColOut, 0);
        for (int k = 1; k <= 120; k++) begin
            step(1);
            if (key_valid === 1'b1) offs.push_back(k);
        end
`ifdef KEYPAD_AUTO_REPEAT_EN
        chk("repeat pulse count", offs.size(), 4);
        for (int i = 0; i < offs.size() && i < 4; i++) begin
            chk("repeat pulse offset", offs[i], 64 + 16 * i);
        end
`else
        chk("no repeat pulses", offs.size(), 0);
`endif
        keys[3][0] = 1'b0;
        step(12);
        chk("hold released", key_held, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
